// File: rtl/alu_execute_unit.sv
// alu_execute_unit: ALU execute stage; single-cycle logic/add/sub/shift, iterative signed mult/div into HI/LO.
// Ports: clk, reset (async, active-high), Start/Busy/Done handshake, ALU_control op code,
// Operand_A/Operand_B/Shamt in, registered Result/Zero, Div_by_zero pulse, HI/LO out.
// Optional Overflow output for add/sub when ALU_OVERFLOW_EN is defined.
module alu_execute_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [3:0]         ALU_control,
  input  logic [WIDTH-1:0]   Operand_A,
  input  logic [WIDTH-1:0]   Operand_B,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic [WIDTH-1:0]   Result,
  output logic               Zero,
  output logic               Busy,
  output logic               Done,
  output logic               Div_by_zero,
  output logic [WIDTH-1:0]   HI,
  output logic [WIDTH-1:0]   LO
`ifdef ALU_OVERFLOW_EN
  , output logic             Overflow
`endif
);
  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
  state_t state, next;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, q, m, acc_n, q_n, rem_f, quo_f, abs_a, abs_b, sum, diff, sc_res;
  logic [WIDTH:0] msum, dsh, ddiff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic div_op, sa, sb, is_md, div_zero, go_iter, take;
  assign take     = state == IDLE && Start;
  assign is_md    = ALU_control[3:1] == 3'b001;
  assign div_zero = ALU_control == 4'b0011 && Operand_B == '0;
  assign go_iter  = is_md && !div_zero;
  assign sum      = Operand_A + Operand_B;
  assign diff     = Operand_A - Operand_B;
  assign abs_a    = Operand_A[WIDTH-1] ? -Operand_A : Operand_A;
  assign abs_b    = Operand_B[WIDTH-1] ? -Operand_B : Operand_B;
  always_comb
    sc_res = ALU_control == 4'b0000 ? sum :
             ALU_control == 4'b0001 ? diff :
             ALU_control == 4'b0100 ? Operand_B << Shamt :
             ALU_control == 4'b0101 ? Operand_B >> Shamt :
             ALU_control == 4'b1000 ? Operand_A & Operand_B :
             ALU_control == 4'b1001 ? Operand_A | Operand_B :
             ALU_control == 4'b1010 ? Operand_A ^ Operand_B :
             ALU_control == 4'b1011 ? ~(Operand_A | Operand_B) : '0;
`ifdef ALU_OVERFLOW_EN
  logic sc_ovf;
  always_comb
    sc_ovf = ALU_control == 4'b0000 ? (Operand_A[WIDTH-1] == Operand_B[WIDTH-1] && sum[WIDTH-1] != Operand_A[WIDTH-1]) :
             ALU_control == 4'b0001 ? (Operand_A[WIDTH-1] != Operand_B[WIDTH-1] && diff[WIDTH-1] != Operand_A[WIDTH-1]) : 1'b0;
`endif
  // acc:q is the {partial product, multiplier} pair for mult and {remainder, dividend} pair for div
  assign msum  = {1'b0, acc} + {1'b0, m & {WIDTH{q[0]}}};
  assign dsh   = {acc, q[WIDTH-1]};
  assign ddiff = dsh - {1'b0, m};
  assign acc_n = div_op ? (ddiff[WIDTH] ? dsh[WIDTH-1:0] : ddiff[WIDTH-1:0]) : msum[WIDTH:1];
  assign q_n   = div_op ? {q[WIDTH-2:0], ~ddiff[WIDTH]} : {msum[0], q[WIDTH-1:1]};
  assign prod   = {acc_n, q_n};
  assign prod_s = (sa ^ sb) ? -prod : prod;
  // remainder follows the dividend sign, quotient the xor of signs
  assign quo_f = div_op ? ((sa ^ sb) ? -q_n : q_n) : prod_s[WIDTH-1:0];
  assign rem_f = div_op ? (sa ? -acc_n : acc_n) : prod_s[2*WIDTH-1:WIDTH];
  assign Busy = state != IDLE;
  assign Done = state == FIN;
  always_comb begin
    next = state;
    if (take) next = go_iter ? ITER : FIN;
    else if (state == ITER && cnt == '0) next = FIN;
    else if (state == FIN) next = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      Result      <= '0;
      Zero        <= 1'b1;
      HI          <= '0;
      LO          <= '0;
      Div_by_zero <= 1'b0;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      div_op      <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      Overflow    <= 1'b0;
`endif
    end else begin
      Div_by_zero <= take && div_zero;
      if (take) begin
        div_op <= ALU_control[0];
        sa     <= Operand_A[WIDTH-1];
        sb     <= Operand_B[WIDTH-1];
        acc    <= '0;
        q      <= abs_a;
        m      <= abs_b;
        cnt    <= SHAMT_W'(WIDTH - 1);
        if (!go_iter) begin
          Result   <= sc_res;
          Zero     <= sc_res == '0;
`ifdef ALU_OVERFLOW_EN
          Overflow <= sc_ovf;
`endif
        end
      end else if (state == ITER) begin
        acc <= acc_n;
        q   <= q_n;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          HI       <= rem_f;
          LO       <= quo_f;
          Result   <= quo_f;
          Zero     <= quo_f == '0;
`ifdef ALU_OVERFLOW_EN
          Overflow <= 1'b0;
`endif
        end
      end
    end
endmodule

// File: doc/alu_execute_unit.md
Name: alu_execute_unit

Overview:
- Execution end of the ALU control interface. Consumes the 4-bit ALU_control code produced by the ALU decoder and performs the operation on two operands.
- Logic, add/sub and shift ops complete in one cycle. Signed mult/div run iteratively over multiple cycles under a Start/Busy/Done handshake and write the HI/LO registers.
- Sits in the execute stage between the register-file read ports and writeback.

Parameters:
- WIDTH, 32, operand/result width; mult/div iteration count.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- ALU_control  input  4  op code: 0000 add, 0001 sub, 0010 mult, 0011 div, 0100 sll, 0101 srl, 1000 and, 1001 or, 1010 xor, 1011 nor.
- Operand_A  input  WIDTH  rs operand.
- Operand_B  input  WIDTH  rt operand.
- Shamt  input  SHAMT_W  shift amount.
- Result  output  WIDTH  registered result.
- Zero  output  1  registered, (Result==0).
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle completion pulse.
- Div_by_zero  output  1  pulses with Done when a div has Operand_B==0.
- HI  output  WIDTH  mult upper half / div remainder.
- LO  output  WIDTH  mult lower half / div quotient.

Behaviour:
- Reset (async, any state): state=IDLE. Result, HI, LO = 0. Zero=1. Busy, Done, Div_by_zero = 0. Any operation in flight is abandoned; HI/LO are not partially updated.
- FSM states: IDLE, ITER, FIN.
- IDLE + Start: latch ALU_control, Operand_A, Operand_B, Shamt.
  - mult/div with nonzero divisor: go to ITER, counter=WIDTH-1.
  - All other ops: go to FIN.
- ITER: one shift-add (mult) or restoring shift-subtract (div) step per cycle, on operand magnitudes. Go to FIN when counter==0.
- FIN: Result, Zero, HI, LO and Div_by_zero update at entry. Done=1 for this single cycle. Next state is IDLE.
- Start is ignored while Busy=1, including in FIN. Back-to-back single-cycle ops can therefore issue every 2 cycles.
- Latency, measured from the edge that samples Start to the edge at which Done is high:
  - single-cycle ops: 1 cycle;
  - mult/div: WIDTH+1 cycles (33 at default).
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no trap.
  - sll/srl shift Operand_B by Shamt, zero fill.
  - nor = ~(A|B).
- mult: signed 2·WIDTH-bit product. HI=upper half, LO=lower half, Result=LO.
- div: signed, quotient truncates toward zero; remainder takes the sign of the dividend. LO=quotient, HI=remainder, Result=quotient. Most-negative / -1 gives quotient 0x80000000, remainder 0.
- Divide by zero: 1-cycle latency. Result=0, HI/LO unchanged, Div_by_zero=1 with Done.
- Undefined ALU_control codes: 1-cycle latency, Result=0, HI/LO unchanged.
- HI/LO change only on completion of mult/div; all other ops leave them unchanged.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: adds output Overflow (1 bit), registered, valid with Done.
  - High for add when operand signs match and the result sign differs.
  - High for sub when operand signs differ and the result sign differs from A.
  - 0 for all other ops; 0 on reset.
  - Result is still written.
- Undefined: port absent; no overflow logic is built.

Test Plan:
- Reset mid-mult (assert reset at iteration 10) -> Busy=0, Done=0, HI=LO=Result=0 immediately; next add 5+7 gives Result=12 with Done 1 cycle after Start.
- sub A=3, B=3 -> Result=0, Zero=1, Done 1 cycle after Start; HI/LO unchanged.
- mult A=-3, B=7 -> Done exactly 33 cycles after Start; HI=0xFFFFFFFF, LO=0xFFFFFFEB, Result=0xFFFFFFEB; Busy high for 33 cycles; a Start pulse mid-op is ignored.
- div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 33 cycles; then div A=9, B=0 -> Done after 1 cycle, Div_by_zero=1, Result=0, HI/LO still hold the prior values.
- sll B=0x00000001, Shamt=31 -> Result=0x80000000; srl B=0x80000000, Shamt=31 -> Result=0x00000001; nor A=B=0 -> Result=0xFFFFFFFF.
- With ALU_OVERFLOW_EN: add 0x7FFFFFFF+1 -> Result=0x80000000, Overflow=1; sub 0x80000000-1 -> Result=0x7FFFFFFF, Overflow=1; and any values -> Overflow=0.
